vx_tcu_mul_sched: RTL and testbench
===================================

VX_TCU_MUL_SCHED -- requirements
Module: VX_tcu_mul_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, the number of requesters sharing one bf16 multiplier (range 2..16).
REQ-002 SHALL have parameter IDX_W, default `CLOG2(NUM_REQS), the requester index width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQS  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  NUM_REQS  per-requester accept; one-hot or zero.
REQ-007 SHALL have port req_a  input  NUM_REQS*16  bf16 operand A, requester i at bits [16i+15:16i].
REQ-008 SHALL have port req_b  input  NUM_REQS*16  bf16 operand B, same packing as req_a.
REQ-009 SHALL have port rsp_valid  output  1  result register holds a valid product.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port rsp_data  output  32  fp32 product.
REQ-012 SHALL have port rsp_idx  output  IDX_W  index of the requester that owns rsp_data.

Function
REQ-013 SHALL instantiate exactly one VX_tcu_bf16mul and share it among all requesters.
REQ-014 SHALL grant at most one requester per cycle using round-robin priority: the search starts at last_grant+1 and wraps modulo NUM_REQS.
REQ-015 SHALL assert req_ready[i] only for the granted requester, and only when slot_free = ~rsp_valid | rsp_ready.
REQ-016 SHALL make req_ready independent of req_a/req_b; it may depend on req_valid (no combinational loop with the requester's valid).
REQ-017 SHALL define a transfer as req_valid[i] & req_ready[i], and on a transfer SHALL drive the multiplier with the granted requester's operands and enable=1.
REQ-018 SHALL update last_grant to i only on a transfer; a grant with no slot free SHALL leave last_grant unchanged.
REQ-019 SHALL load the multiplier output into the result register on the clock edge of a transfer, so latency is exactly 1 cycle from transfer to rsp_valid=1, with rsp_idx=i.
REQ-020 SHALL implement the output stage as a two-state machine, EMPTY and FULL:
  - EMPTY->FULL on a transfer.
  - FULL->FULL on (rsp_ready & transfer), which is a back-to-back replace.
  - FULL->EMPTY on rsp_ready with no transfer.
  - FULL holds on ~rsp_ready, with rsp_data and rsp_idx stable.
REQ-021 SHALL sustain a throughput of one product per cycle while rsp_ready=1 and any req_valid=1.
REQ-022 SHALL drive the multiplier enable to 0 when there is no transfer, and SHALL hold the result register in that case.
REQ-023 SHALL, for a single active requester, grant it every cycle regardless of last_grant.
REQ-024 SHALL tolerate req_valid deasserting without a transfer (no latched grant); arbitration is re-evaluated every cycle.

Reset
REQ-025 SHALL, while reset_n=0, force: state=EMPTY, rsp_valid=0, rsp_data=0, rsp_idx=0, last_grant=NUM_REQS-1 (requester 0 has first priority), req_ready=0.
REQ-026 SHALL, on reset assertion mid-operation, drop any held result immediately and asynchronously, without it being delivered.
REQ-027 SHALL require reset deassertion to be synchronized externally, and SHALL accept no transfer in the cycle reset_n rises.

Configuration
REQ-028 SHALL, with TCU_MUL_SCHED_PERF_EN defined, add these outputs, each cleared by reset and saturating at 0xFFFFFFFF:
  - perf_ops output 32: counts transfers.
  - perf_stalls output 32: counts cycles with rsp_valid & ~rsp_ready & |req_valid.
REQ-029 SHALL, without TCU_MUL_SCHED_PERF_EN, not declare those ports or counters; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL cover: reset, then req_valid=4'b0001 with a=0x3F80, b=0x4000 and rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x40000000, rsp_idx=0.
REQ-031 SHALL cover: all four requesters valid continuously with rsp_ready=1 -> rsp_idx sequence 0,1,2,3,0,... with one result per cycle.
REQ-032 SHALL cover: requester 2 with a=0x3FC0, b=0x3FC0 and rsp_ready held 0 for 3 cycles -> rsp_data=0x40100000 stable, req_ready=0, last_grant unchanged; when rsp_ready=1, the next grant is requester 3.
REQ-033 SHALL cover: a=0x7F80 (inf), b=0x0000 -> rsp_data=0x7FC00000; a=0xBF80, b=0x3F80 -> rsp_data=0xBF800000.
REQ-034 SHALL cover: reset_n pulsed low while FULL -> rsp_valid=0 in that same cycle, and the next transfer goes to requester 0 if valid.
REQ-035 SHALL cover, with TCU_MUL_SCHED_PERF_EN defined: 10 transfers and 3 stall cycles -> perf_ops=10, perf_stalls=3.

Source files
------------

// File: rtl/vx_tcu_mul_sched.sv
// ---------------------------------------------------------------------------
// vx_tcu_mul_sched
//
// Purpose:
//    Shares a single bf16 x bf16 -> fp32 multiplier among NUM_REQS
//    requesters. Each cycle a round-robin arbiter picks at most one valid
//    requester. Its operands go through the multiplier, and the product is
//    captured in a one-entry result register on the same clock edge.
//    The result register is a two-state EMPTY/FULL stage. It can be
//    replaced back-to-back, so while the consumer keeps rsp_ready high the
//    module sustains one product per cycle.
//
// Ports:
//    clk        - the only clock; all state updates on its rising edge
//    reset_n    - asynchronous, active-low reset (deassertion synchronized
//                 externally)
//    req_valid  - [NUM_REQS] per-requester operand valid
//    req_ready  - [NUM_REQS] per-requester accept, one-hot or zero
//    req_a      - [NUM_REQS*16] bf16 operand A, requester i at [16i+15:16i]
//    req_b      - [NUM_REQS*16] bf16 operand B, same packing as req_a
//    rsp_valid  - the result register holds a valid product
//    rsp_ready  - the consumer accepts the result
//    rsp_data   - [32] fp32 product
//    rsp_idx    - [IDX_W] index of the requester that owns rsp_data
//    perf_ops   - [32] saturating count of accepted operand transfers
//                 (only with TCU_MUL_SCHED_PERF_EN)
//    perf_stalls- [32] saturating count of cycles where a held result blocks
//                 waiting requesters (only with TCU_MUL_SCHED_PERF_EN)
//
// Configuration macro:
//    TCU_MUL_SCHED_PERF_EN - adds the perf_ops / perf_stalls counters.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// VX_tcu_bf16mul
//
// Purpose:
//    Combinational bf16 x bf16 multiplier producing an fp32 result. Two
//    8-bit significands give a 16-bit product, which always fits in the
//    24-bit fp32 significand, so normal results are exact and need no
//    rounding. Subnormal inputs and subnormal results are flushed to signed
//    zero. Any NaN input, or inf x 0, gives the canonical quiet NaN
//    0x7FC00000. The output is forced to zero while enable is low.
//
// Ports:
//    enable - 1 when the operands are being consumed this cycle
//    a, b   - [16] bf16 operands
//    result - [32] fp32 product
// ---------------------------------------------------------------------------
module VX_tcu_bf16mul (
   input  logic        enable,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] result
);

   logic       sign;
   logic [7:0] exp_a;
   logic [7:0] exp_b;
   logic [6:0] frac_a;
   logic [6:0] frac_b;
   logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [15:0] sig_prod;
   logic        norm_shift;
   logic [9:0]  exp_sum;
   logic [22:0] frac_out;
   logic        exp_overflow;
   logic        exp_underflow;

   // Field extraction and operand classification. An exponent field of zero
   // is treated as zero whether or not the fraction is nonzero (FTZ).
   always_comb begin
      sign   = a[15] ^ b[15];
      exp_a  = a[14:7];
      exp_b  = b[14:7];
      frac_a = a[6:0];
      frac_b = b[6:0];
      a_nan  = (exp_a == 8'hFF) && (frac_a != 7'd0);
      b_nan  = (exp_b == 8'hFF) && (frac_b != 7'd0);
      a_inf  = (exp_a == 8'hFF) && (frac_a == 7'd0);
      b_inf  = (exp_b == 8'hFF) && (frac_b == 7'd0);
      a_zero = (exp_a == 8'h00);
      b_zero = (exp_b == 8'h00);
   end

   // Significand product and exponent. The product of two values in
   // [1,2) lies in [1,4). When the top bit is set, the value is >= 2 and the
   // exponent gains one. The exponent is kept 10 bits wide so that overflow
   // (>= 255) and underflow (<= 0, sign bit set) can both be detected.
   always_comb begin
      sig_prod   = {1'b1, frac_a} * {1'b1, frac_b};
      norm_shift = sig_prod[15];
      exp_sum    = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127 + {9'd0, norm_shift};
      if (norm_shift) begin
         frac_out = {sig_prod[14:0], 8'd0};
      end else begin
         frac_out = {sig_prod[13:0], 9'd0};
      end
      exp_overflow  = !exp_sum[9] && (exp_sum >= 10'd255);
      exp_underflow = exp_sum[9] || (exp_sum == 10'd0);
   end

   // Final result selection. Special operands take priority over the
   // arithmetic path. Underflowed results flush to a zero that keeps the
   // sign.
   always_comb begin
      result = 32'd0;
      if (enable) begin
         if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            result = 32'h7FC0_0000;
         end else if (a_inf || b_inf) begin
            result = {sign, 8'hFF, 23'd0};
         end else if (a_zero || b_zero) begin
            result = {sign, 31'd0};
         end else if (exp_overflow) begin
            result = {sign, 8'hFF, 23'd0};
         end else if (exp_underflow) begin
            result = {sign, 31'd0};
         end else begin
            result = {sign, exp_sum[7:0], frac_out};
         end
      end
   end

endmodule

module vx_tcu_mul_sched #(
   parameter int NUM_REQS = 4,
   parameter int IDX_W    = $clog2(NUM_REQS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQS-1:0]    req_valid,
   output logic [NUM_REQS-1:0]    req_ready,
   input  logic [NUM_REQS*16-1:0] req_a,
   input  logic [NUM_REQS*16-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [31:0]            rsp_data,
   output logic [IDX_W-1:0]       rsp_idx
`ifdef TCU_MUL_SCHED_PERF_EN
   ,
   output logic [31:0]            perf_ops,
   output logic [31:0]            perf_stalls
`endif
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_next;
   logic [IDX_W-1:0] last_grant;
   logic             run_q;
   logic [IDX_W:0]   cand;
   logic             grant_found;
   logic [IDX_W-1:0] grant_idx;
   logic             slot_free;
   logic             transfer;
   logic [15:0]      mul_a;
   logic [15:0]      mul_b;
   logic [31:0]      mul_result;

   assign rsp_valid = (state == FULL);
   assign slot_free = ~rsp_valid | rsp_ready;

   // Round-robin search. Candidates are visited starting at last_grant+1
   // and wrapping modulo NUM_REQS, so the last winner is tried last. A lone
   // valid requester is always found, whatever last_grant holds. Nothing is
   // latched: the winner is recomputed from req_valid every cycle.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NUM_REQS; k++) begin
         cand = {1'b0, last_grant} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQS)) begin
            cand = cand - (IDX_W+1)'(NUM_REQS);
         end
         if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // Accept is offered only to the winner, and only when the result slot
   // can take a new product. run_q keeps ready low through the first edge
   // after reset release, so no transfer happens in the cycle reset_n
   // rises. Ready depends on req_valid but never on the operand data.
   always_comb begin
      req_ready = '0;
      if (grant_found && slot_free && run_q) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign transfer = |(req_valid & req_ready);

   // Operand steering into the shared multiplier. The multiplier is
   // enabled only on a real transfer.
   always_comb begin
      mul_a = req_a[{grant_idx, 4'b0000} +: 16];
      mul_b = req_b[{grant_idx, 4'b0000} +: 16];
   end

   VX_tcu_bf16mul u_mul (
      .enable (transfer),
      .a      (mul_a),
      .b      (mul_b),
      .result (mul_result)
   );

   // Output-stage next state. A transfer while FULL can only happen when
   // rsp_ready is high (slot_free), which makes it a back-to-back replace.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY: begin
            if (transfer) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (rsp_ready && !transfer) begin
               state_next = EMPTY;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   // State, result register and arbitration pointer. Reset discards any
   // held result at once. The product and owner index are loaded only on a
   // transfer and are otherwise held, so a stalled result stays stable.
   // last_grant moves only when a transfer actually happens.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= EMPTY;
         rsp_data   <= 32'd0;
         rsp_idx    <= '0;
         last_grant <= IDX_W'(NUM_REQS-1);
         run_q      <= 1'b0;
      end else begin
         state <= state_next;
         run_q <= 1'b1;
         if (transfer) begin
            rsp_data   <= mul_result;
            rsp_idx    <= grant_idx;
            last_grant <= grant_idx;
         end
      end
   end

`ifdef TCU_MUL_SCHED_PERF_EN
   logic stall_cycle;

   assign stall_cycle = rsp_valid & ~rsp_ready & (|req_valid);

   // Saturating activity counters. perf_stalls counts cycles where a result
   // is held and at least one requester is waiting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_ops    <= 32'd0;
         perf_stalls <= 32'd0;
      end else begin
         if (transfer && (perf_ops != 32'hFFFF_FFFF)) begin
            perf_ops <= perf_ops + 32'd1;
         end
         if (stall_cycle && (perf_stalls != 32'hFFFF_FFFF)) begin
            perf_stalls <= perf_stalls + 32'd1;
         end
      end
   end
`else
   // Counters are not built; datapath and handshakes are unchanged.
`endif

endmodule

// File: tb/tb_vx_tcu_mul_sched.sv
// ---------------------------------------------------------------------------
// tb_vx_tcu_mul_sched
//
// Purpose:
//    Directed self-checking bench for vx_tcu_mul_sched with NUM_REQS=4.
//    It covers: reset values, first-transfer latency, round-robin order,
//    holding a stalled result, special-value products, asynchronous reset
//    while FULL, and (with TCU_MUL_SCHED_PERF_EN) the performance counters.
//    Inputs change on the falling clock edge. Outputs are sampled on the
//    falling edge, or 1 ns after it for combinational ready.
// ---------------------------------------------------------------------------
module tb_vx_tcu_mul_sched;

   localparam int NUM_REQS = 4;
   localparam int IDX_W    = 2;

   logic                   clk;
   logic                   reset_n;
   logic [NUM_REQS-1:0]    req_valid;
   logic [NUM_REQS-1:0]    req_ready;
   logic [NUM_REQS*16-1:0] req_a;
   logic [NUM_REQS*16-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [31:0]            rsp_data;
   logic [IDX_W-1:0]       rsp_idx;
`ifdef TCU_MUL_SCHED_PERF_EN
   logic [31:0]            perf_ops;
   logic [31:0]            perf_stalls;
`endif

   int assertCount = 0;
   int failCount   = 0;

   // Hand-computed fp32 products for requester i operands (i+1.0) x 1.0.
   localparam logic [31:0] RR_PROD [4] = '{32'h3F80_0000, 32'h4000_0000,
                                           32'h4040_0000, 32'h4080_0000};

   // Special-value vectors: inf*0, -1*1, 2*-2, inf*2, -0*1, overflow.
   localparam logic [15:0] VEC_A [6] = '{16'h7F80, 16'hBF80, 16'h4000,
                                         16'h7F80, 16'h8000, 16'h7F00};
   localparam logic [15:0] VEC_B [6] = '{16'h0000, 16'h3F80, 16'hC000,
                                         16'h4000, 16'h3F80, 16'h4000};
   localparam logic [31:0] VEC_P [6] = '{32'h7FC0_0000, 32'hBF80_0000,
                                         32'hC080_0000, 32'h7F80_0000,
                                         32'h8000_0000, 32'h7F80_0000};

   vx_tcu_mul_sched #(
      .NUM_REQS (NUM_REQS),
      .IDX_W    (IDX_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_idx     (rsp_idx)
`ifdef TCU_MUL_SCHED_PERF_EN
      ,
      .perf_ops    (perf_ops),
      .perf_stalls (perf_stalls)
`endif
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive requester valids and consumer ready together
   task automatic applyStimulus(input logic [NUM_REQS-1:0] valid, input logic ready);
      req_valid = valid;
      rsp_ready = ready;
   endtask

   // Load one requester's operand pair
   task automatic setOps(input int idx, input logic [15:0] a, input logic [15:0] b);
      req_a[idx*16 +: 16] = a;
      req_b[idx*16 +: 16] = b;
   endtask

   // Advance to the next falling edge
   task automatic step();
      @(negedge clk);
   endtask

   // Full reset sequence, ending one cycle after release so ready can rise
   task automatic doReset();
      reset_n = 1'b0;
      applyStimulus(4'b0000, 1'b1);
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      setOps(0, 16'h3F80, 16'h4000);

      // Reset state, with all requesters valid to confirm ready is held low
      applyStimulus(4'b1111, 1'b1);
      step();
      step();
      #1;
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_rsp_data",  64'(rsp_data),  64'd0);
      checkOutput("reset_rsp_idx",   64'(rsp_idx),   64'd0);
      checkOutput("reset_req_ready", 64'(req_ready), 64'd0);

      // No transfer in the cycle reset_n rises
      step();
      reset_n = 1'b1;
      #1;
      checkOutput("rise_req_ready", 64'(req_ready), 64'd0);
      step();
      checkOutput("rise_no_xfer", 64'(rsp_valid), 64'd0);

      // First product: 1.0 * 2.0 from requester 0, one-cycle latency
      applyStimulus(4'b0001, 1'b1);
      #1;
      checkOutput("first_ready", 64'(req_ready), 64'h1);
      step();
      checkOutput("first_valid", 64'(rsp_valid), 64'd1);
      checkOutput("first_data",  64'(rsp_data),  64'h4000_0000);
      checkOutput("first_idx",   64'(rsp_idx),   64'd0);
      applyStimulus(4'b0000, 1'b1);
      step();
      checkOutput("drain_empty", 64'(rsp_valid), 64'd0);

      // Round robin with all four requesters valid: 0,1,2,3,0,1,2,3
      doReset();
      for (int i = 0; i < NUM_REQS; i++) begin
         setOps(i, 16'h3F80 + 16'(i == 0 ? 0 : 0), 16'h3F80);
      end
      setOps(1, 16'h4000, 16'h3F80);
      setOps(2, 16'h4040, 16'h3F80);
      setOps(3, 16'h4080, 16'h3F80);
      applyStimulus(4'b1111, 1'b1);
      for (int k = 0; k < 8; k++) begin
         #1;
         checkOutput("rr_ready", 64'(req_ready), 64'(1) << (k % 4));
         step();
         checkOutput("rr_valid", 64'(rsp_valid), 64'd1);
         checkOutput("rr_idx",   64'(rsp_idx),   64'(k % 4));
         checkOutput("rr_data",  64'(rsp_data),  64'(RR_PROD[k % 4]));
      end
      applyStimulus(4'b0000, 1'b1);
      step();

      // Stalled result from requester 2 (1.5*1.5) held for three cycles
      setOps(2, 16'h3FC0, 16'h3FC0);
      applyStimulus(4'b0100, 1'b0);
      #1;
      checkOutput("stall_grant", 64'(req_ready), 64'h4);
      step();
      applyStimulus(4'b1111, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput("stall_valid", 64'(rsp_valid), 64'd1);
         checkOutput("stall_data",  64'(rsp_data),  64'h4010_0000);
         checkOutput("stall_idx",   64'(rsp_idx),   64'd2);
         checkOutput("stall_ready", 64'(req_ready), 64'd0);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      checkOutput("stall_next_grant", 64'(req_ready), 64'h8);
      step();
      checkOutput("replace_idx",  64'(rsp_idx),  64'd3);
      checkOutput("replace_data", 64'(rsp_data), 64'h4080_0000);
      applyStimulus(4'b0000, 1'b1);
      step();

      // Special values from a lone requester 0, granted every cycle
      applyStimulus(4'b0001, 1'b1);
      for (int v = 0; v < 6; v++) begin
         setOps(0, VEC_A[v], VEC_B[v]);
         #1;
         checkOutput("single_ready", 64'(req_ready), 64'h1);
         step();
         checkOutput("special_data", 64'(rsp_data), 64'(VEC_P[v]));
         checkOutput("special_idx",  64'(rsp_idx),  64'd0);
      end
      applyStimulus(4'b0000, 1'b1);
      step();

      // Asynchronous reset while FULL drops the held result immediately
      setOps(1, 16'h4000, 16'h4000);
      applyStimulus(4'b0010, 1'b0);
      step();
      checkOutput("full_before_reset", 64'(rsp_valid), 64'd1);
      checkOutput("full_idx",          64'(rsp_idx),   64'd1);
      checkOutput("full_data",         64'(rsp_data),  64'h4080_0000);
      reset_n = 1'b0;
      #1;
      checkOutput("async_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("async_rsp_data",  64'(rsp_data),  64'd0);
      checkOutput("async_req_ready", 64'(req_ready), 64'd0);
      step();
      step();
      setOps(0, 16'h3F80, 16'h4000);
      applyStimulus(4'b1111, 1'b1);
      reset_n = 1'b1;
      #1;
      checkOutput("rerise_ready", 64'(req_ready), 64'd0);
      step();
      #1;
      checkOutput("post_reset_grant", 64'(req_ready), 64'h1);
      step();
      checkOutput("post_reset_idx",  64'(rsp_idx),  64'd0);
      checkOutput("post_reset_data", 64'(rsp_data), 64'h4000_0000);
      applyStimulus(4'b0000, 1'b1);
      step();

`ifdef TCU_MUL_SCHED_PERF_EN
      // Ten transfers, then three stalled cycles with a waiting requester
      doReset();
      checkOutput("perf_ops_reset",    64'(perf_ops),    64'd0);
      checkOutput("perf_stalls_reset", 64'(perf_stalls), 64'd0);
      applyStimulus(4'b0001, 1'b1);
      repeat (10) step();
      rsp_ready = 1'b0;
      repeat (3) step();
      applyStimulus(4'b0000, 1'b1);
      step();
      checkOutput("perf_ops",    64'(perf_ops),    64'd10);
      checkOutput("perf_stalls", 64'(perf_stalls), 64'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
